// File: rtl/alu_seq_ctrl.sv
// alu_seq_ctrl: multi-cycle sequencer for unsigned MUL / DIVU / REMU.
// A single WIDTH+1-bit adder is steered with invB/Cin controls:
// shift-add for multiply, restoring shift-subtract for divide.
// busy/stall are high while an operation iterates, and done pulses for
// one cycle with result/err. result/err hold until the next accepted start.
module alu_seq_ctrl #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] result,
    output logic             busy,
    output logic             stall,
    output logic             done,
    output logic             err
);

    localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;
    typedef enum logic [1:0] {OP_MUL, OP_DIVU, OP_REMU, OP_RSVD} op_t;

    state_t           state_q, state_d;
    op_t              op_q, op_d;
    logic [WIDTH-1:0] opa_q, opa_d;     // multiplicand / dividend
    logic [WIDTH-1:0] opb_q, opb_d;     // multiplier / divisor
    logic [WIDTH-1:0] acc_q, acc_d;     // product accumulator / remainder
    logic [WIDTH-1:0] quo_q, quo_d;     // quotient
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             err_q, err_d;

    logic             is_mul;
    logic             add_invb;
    logic             add_cin;
    logic [WIDTH-1:0] rem_shift;
    logic [WIDTH-1:0] add_x;
    logic [WIDTH-1:0] add_y;
    logic [WIDTH:0]   sum;
    logic             carry;

    // Shared adder: X + (invB ? ~Y : Y) + Cin with carry-out (invA fixed at 0)
    always_comb begin
        is_mul    = (op_q == OP_MUL);
        add_invb  = ~is_mul;
        add_cin   = ~is_mul;
        rem_shift = {acc_q[WIDTH-2:0], opa_q[WIDTH-1]};
        add_x     = is_mul ? acc_q : rem_shift;
        add_y     = is_mul ? opa_q : opb_q;
        sum       = {1'b0, add_x}
                  + {1'b0, (add_invb ? ~add_y : add_y)}
                  + {{WIDTH{1'b0}}, add_cin};
        carry     = sum[WIDTH];
    end

    // Next-state and datapath control for IDLE / RUN / DONE
    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        opa_d    = opa_q;
        opb_d    = opb_q;
        acc_d    = acc_q;
        quo_d    = quo_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        err_d    = err_q;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    op_d  = op_t'(op);
                    opa_d = a;
                    opb_d = b;
                    acc_d = '0;
                    quo_d = '0;
                    cnt_d = '0;
                    err_d = 1'b0;
                    if (op_t'(op) == OP_RSVD) begin
                        state_d  = S_DONE;
                        err_d    = 1'b1;
                        result_d = '0;
                    end else if (op_t'(op) != OP_MUL && b == '0) begin
                        state_d  = S_DONE;
                        err_d    = 1'b1;
                        result_d = (op_t'(op) == OP_DIVU) ? '1 : a;
                    end else begin
                        state_d = S_RUN;
                    end
                end else if (state_q == S_DONE) begin
                    state_d = S_IDLE;
                end
            end
            S_RUN: begin
                if (is_mul) begin
                    if (opb_q[0]) acc_d = sum[WIDTH-1:0];
                    opa_d = opa_q << 1;
                    opb_d = opb_q >> 1;
                end else begin
                    if (carry) begin
                        acc_d = sum[WIDTH-1:0];
                        quo_d = {quo_q[WIDTH-2:0], 1'b1};
                    end else begin
                        acc_d = rem_shift;
                        quo_d = {quo_q[WIDTH-2:0], 1'b0};
                    end
                    opa_d = opa_q << 1;
                end
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(WIDTH - 1)) begin
                    state_d  = S_DONE;
                    cnt_d    = '0;
                    result_d = (op_q == OP_DIVU) ? quo_d : acc_d;
                end
            end
            default: state_d = S_IDLE;
        endcase

        busy_d = (state_d == S_RUN);
        done_d = (state_d == S_DONE);
    end

    // State and output registers, synchronous active-high reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            op_q     <= OP_MUL;
            opa_q    <= '0;
            opb_q    <= '0;
            acc_q    <= '0;
            quo_q    <= '0;
            cnt_q    <= '0;
            result_q <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            opa_q    <= opa_d;
            opb_q    <= opb_d;
            acc_q    <= acc_d;
            quo_q    <= quo_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            err_q    <= err_d;
        end
    end

    assign result = result_q;
    assign busy   = busy_q;
    assign stall  = busy_q;
    assign done   = done_q;
    assign err    = err_q;

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Directed bench for alu_seq_ctrl with hand-computed expected values.
module tb_alu_seq_ctrl;

    localparam int unsigned WIDTH = 16;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] result;
    logic             busy;
    logic             stall;
    logic             done;
    logic             err;

    int errors = 0;
    int checks = 0;

    alu_seq_ctrl #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .op    (op),
        .a     (a),
        .b     (b),
        .result(result),
        .busy  (busy),
        .stall (stall),
        .done  (done),
        .err   (err)
    );

    always #5 clk = ~clk;

    // Advance one clock and sample 1 time unit after the rising edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Launch one op, wait (bounded) for done, check busy/stall along the way
    task automatic run_op(input string tag, input logic [1:0] o, input logic [15:0] va,
                          input logic [15:0] vb, input logic [15:0] exp_res,
                          input logic exp_err, input int exp_lat);
        int   n;
        logic busy_bad;
        op = o; a = va; b = vb; start = 1'b1;
        step();
        start = 1'b0;
        n = 1;
        busy_bad = 1'b0;
        while (!done && n < 40) begin
            if (busy !== 1'b1 || stall !== 1'b1) busy_bad = 1'b1;
            step();
            n++;
        end
        chk({tag, "_lat"},    n, exp_lat);
        chk({tag, "_busyrun"}, {31'd0, busy_bad}, 32'd0);
        chk({tag, "_res"},    {16'd0, result}, {16'd0, exp_res});
        chk({tag, "_err"},    {31'd0, err}, {31'd0, exp_err});
        chk({tag, "_busydn"}, {30'd0, busy, stall}, 32'd0);
        step();
        chk({tag, "_pulse"},  {31'd0, done}, 32'd0);
        chk({tag, "_hold"},   {16'd0, result}, {16'd0, exp_res});
    endtask

    initial begin
        int n;
        logic bad;
        rst = 1'b1; start = 1'b0; op = 2'b00; a = '0; b = '0;
        step();
        step();
        chk("rst_result", {16'd0, result}, 32'd0);
        chk("rst_flags",  {28'd0, busy, stall, done, err}, 32'd0);
        rst = 1'b0;
        step();

        run_op("mul7x9",   2'b00, 16'd7,      16'd9,      16'h003F, 1'b0, 17);
        run_op("mulovf",   2'b00, 16'hFFFF,   16'hFFFF,   16'h0001, 1'b0, 17);
        run_op("mulsh",    2'b00, 16'h1234,   16'h0100,   16'h3400, 1'b0, 17);
        run_op("div100_7", 2'b01, 16'd100,    16'd7,      16'h000E, 1'b0, 17);
        run_op("rem100_7", 2'b10, 16'd100,    16'd7,      16'h0002, 1'b0, 17);
        run_op("divffff1", 2'b01, 16'hFFFF,   16'd1,      16'hFFFF, 1'b0, 17);
        run_op("remffff1", 2'b10, 16'hFFFF,   16'd1,      16'h0000, 1'b0, 17);
        run_op("divbig",   2'b01, 16'hFFFF,   16'h8001,   16'h0001, 1'b0, 17);
        run_op("rembig",   2'b10, 16'hFFFF,   16'h8001,   16'h7FFE, 1'b0, 17);
        run_op("divz",     2'b01, 16'h1234,   16'h0000,   16'hFFFF, 1'b1, 1);
        run_op("remz",     2'b10, 16'h1234,   16'h0000,   16'h1234, 1'b1, 1);
        run_op("rsvd",     2'b11, 16'h1234,   16'h5678,   16'h0000, 1'b1, 1);
        run_op("errclr",   2'b00, 16'd3,      16'd4,      16'h000C, 1'b0, 17);

        // start during RUN is ignored; start in DONE is accepted back-to-back
        op = 2'b00; a = 16'd7; b = 16'd9; start = 1'b1;
        step();
        start = 1'b0;
        n = 1;
        repeat (4) begin step(); n++; end
        op = 2'b01; a = 16'd3; b = 16'd3; start = 1'b1;
        step(); n++;
        start = 1'b0;
        while (!done && n < 40) begin step(); n++; end
        chk("ign_lat", n, 17);
        chk("ign_res", {16'd0, result}, 32'h003F);
        op = 2'b00; a = 16'h1234; b = 16'h0100; start = 1'b1;
        step();
        start = 1'b0;
        chk("b2b_busy", {30'd0, busy, done}, 32'd2);
        n = 1;
        while (!done && n < 40) begin step(); n++; end
        chk("b2b_lat", n, 17);
        chk("b2b_res", {16'd0, result}, 32'h3400);
        step();

        // reset mid-DIVU, then an immediate MUL
        op = 2'b01; a = 16'd100; b = 16'd7; start = 1'b1;
        step();
        start = 1'b0;
        repeat (7) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("midrst_flags",  {28'd0, busy, stall, done, err}, 32'd0);
        chk("midrst_result", {16'd0, result}, 32'd0);
        op = 2'b00; a = 16'd3; b = 16'd5; start = 1'b1;
        step();
        start = 1'b0;
        chk("postrst_busy", {31'd0, busy}, 32'd1);
        n = 1;
        bad = 1'b0;
        while (!done && n < 40) begin step(); n++; end
        chk("postrst_lat", n, 17);
        chk("postrst_res", {16'd0, result}, 32'h000F);
        step();

        // reset and start in the same cycle: reset wins
        op = 2'b00; a = 16'd2; b = 16'd2; start = 1'b1; rst = 1'b1;
        step();
        start = 1'b0; rst = 1'b0;
        chk("rstwin_flags", {28'd0, busy, stall, done, err}, 32'd0);
        step();
        chk("rstwin_idle", {30'd0, busy, done}, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/alu_seq_ctrl.md
# alu_seq_ctrl

Multi-cycle sequencer for 16-bit unsigned MUL, DIVU and REMU in the EX stage. It drives an internal adder through invA/invB/Cin-style controls: shift-add for multiply, restoring shift-subtract for divide. It asserts `stall` to freeze the upstream pipeline while an operation runs. It returns a single-cycle `done` pulse with a held result.

## Interface
Parameters:
- `WIDTH`, 16, operand/result width; iteration count equals `WIDTH`.

Ports:
- `clk`  in  1  — clock; all state updates on the rising edge.
- `rst`  in  1  — reset, synchronous and active-high.
- `start`  in  1  — operation request; sampled only in IDLE or DONE.
- `op`  in  2  — 00 MUL (low WIDTH bits of product), 01 DIVU (quotient), 10 REMU (remainder), 11 reserved.
- `a`  in  WIDTH  — multiplicand / dividend; captured with `start`.
- `b`  in  WIDTH  — multiplier / divisor; captured with `start`.
- `result`  out  WIDTH  — registered result; valid while `done`=1; held until the next accepted `start`.
- `busy`  out  1  — high in RUN.
- `stall`  out  1  — equals `busy`; drives pipeline-hold logic.
- `done`  out  1  — one-cycle pulse in DONE.
- `err`  out  1  — valid with `done`; divide-by-zero or reserved op.

## Operation
- States: IDLE, RUN, DONE.
  - IDLE: waits for `start`.
  - RUN: executes `WIDTH` iterations; the iteration counter runs 0..WIDTH-1.
  - DONE: lasts exactly one cycle.
- Accept: `start`=1 in IDLE or DONE captures `a`, `b`, `op` and clears `err`. The next state follows these rules:
  - op 11: go to DONE with `err`=1 and result 0.
  - DIVU/REMU with `b`=0: go to DONE with `err`=1. DIVU result is all-ones; REMU result is `a`.
  - Otherwise: go to RUN with counter 0 and the accumulator/remainder cleared.
- `start` while in RUN is ignored. It is neither queued nor allowed to corrupt the operands.
- Internal adder: sum = (invA ? ~X : X) + (invB ? ~Y : Y) + Cin, width WIDTH+1 with carry-out. invA is always 0.
- MUL, per RUN cycle:
  - If multiplier LSB=1: acc = acc + multiplicand (invB=0, Cin=0). Otherwise acc is unchanged.
  - Multiplicand shifts left 1; multiplier shifts right 1.
  - Only the low WIDTH bits are kept; overflow is discarded and does not set `err`.
- DIVU/REMU, per RUN cycle:
  - Form rem' = {rem[WIDTH-2:0], dividend MSB}.
  - Trial = rem' − divisor (invB=1, Cin=1).
  - Carry-out=1 (no borrow): rem = trial, and shift quotient bit 1 in.
  - Carry-out=0: rem = rem', and shift 0 in.
  - Dividend shifts left 1.
- On the last RUN cycle (counter = WIDTH-1), the selected result is registered and the state moves to DONE.
- DONE with no `start` goes to IDLE. `result` and `err` hold until the next accepted `start`.

## Timing
- Reset values: state IDLE, `result`=0, `busy`=0, `stall`=0, `done`=0, `err`=0; counter and internal registers 0.
- Normal latency: `start` high in cycle T → `busy`/`stall` high T+1..T+WIDTH → `done` high in T+WIDTH+1 (T+17 for WIDTH=16).
- Error latency: `done`/`err` high in T+1; `busy` never asserts.
- `busy`, `stall`, `done` and `err` are registered and never glitch.
- Back-to-back: `start` in the DONE cycle is accepted, so `busy` is high the following cycle. Throughput is one op per WIDTH+1 cycles.
- Reset mid-RUN: the next cycle is IDLE with all outputs at reset values and no `done` pulse. A `start` in the cycle after `rst` deasserts is accepted.
- `rst` and `start` in the same cycle: reset wins.

## Test plan
- MUL: a=7, b=9, `start` at T → `stall`=1 for T+1..T+16; `done`=1, `result`=0x003F, `err`=0 at T+17.
- MUL overflow: a=0xFFFF, b=0xFFFF → `result`=0x0001, `err`=0. Also a=0x1234, b=0x0100 → `result`=0x3400.
- DIVU/REMU: a=100, b=7 → DIVU `result`=0x000E; REMU `result`=0x0002. Also a=0xFFFF, b=1 → DIVU `result`=0xFFFF, REMU `result`=0.
- Divide-by-zero and reserved op:
  - DIVU a=0x1234, b=0 → `done`=`err`=1 at T+1, `result`=0xFFFF.
  - REMU with b=0 → `result`=0x1234.
  - op=11 → `result`=0, `err`=1.
  - `busy` stays 0 in all three cases.
- `start` pulsed with different operands at T+5 during a MUL 7×9 → ignored; `result`=0x003F at T+17. A second `start` in the DONE cycle → `busy`=1 next cycle, and that op completes correctly.
- `rst` asserted at T+8 of a DIVU → IDLE at T+9, all outputs 0, no `done`. A new MUL 3×5 started immediately after → `result`=0x000F after 17 cycles.
